// File: rtl/io_switch_debounce.sv
// io_switch_debounce: two-flop synchronizers plus per-channel debounce FSMs for SW0, SW1 and PB0,
// with a registered PB0 press pulse, a sticky press flag and the 16-bit switch port read word.
module io_switch_debounce #(
  parameter int unsigned DB_CYCLES = 16'd50000,
  parameter int          CNT_W     = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        raw_sw0,
  input  logic        raw_sw1,
  input  logic        raw_pb0,
  input  logic        clear_press,
  output logic        io_sw0,
  output logic        io_sw1,
  output logic        io_pb0,
  output logic        pb0_press,
  output logic        pb0_latched,
  output logic [15:0] io_rdata
);
  typedef enum logic {ST_STABLE, ST_PENDING} state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  logic [2:0] w_raw;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] w_lvl;
  logic [2:0] w_flip;
  logic       r_press;
  logic       r_latched;
  // channel 0 = PB0, 1 = SW0, 2 = SW1, matching the port word bit order
  assign w_raw = {raw_sw1, raw_sw0, raw_pb0};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    assign w_flip[i] = (r_state == ST_PENDING) && (r_s2[i] != r_level) && (r_cnt == CNT_LAST);
    assign w_lvl[i]  = r_level;
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else begin
        case (r_state)
          ST_STABLE: begin
            r_cnt   <= (r_s2[i] != r_level) ? CNT_W'(1) : '0;
            r_state <= (r_s2[i] != r_level) ? ST_PENDING : ST_STABLE;
          end
          default: begin
            if (r_s2[i] == r_level) begin
              r_cnt   <= '0;
              r_state <= ST_STABLE;
            end else if (r_cnt == CNT_LAST) begin
              r_level <= r_s2[i];
              r_cnt   <= '0;
              r_state <= ST_STABLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        endcase
      end
  end
  // the pulse is raised on the same edge that sets io_pb0, so it spans the first high cycle
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_press   <= 1'b0;
      r_latched <= 1'b0;
    end else begin
      r_press   <= w_flip[0] & r_s2[0];
      r_latched <= r_press | (r_latched & ~clear_press);
    end
  assign io_pb0      = w_lvl[0];
  assign io_sw0      = w_lvl[1];
  assign io_sw1      = w_lvl[2];
  assign pb0_press   = r_press;
  assign pb0_latched = r_latched;
  assign io_rdata    = {13'd0, w_lvl[2], w_lvl[1], w_lvl[0]};
endmodule

// File: tb/tb_io_switch_debounce.sv
// tb_io_switch_debounce: directed latency check plus randomized stimulus against a run-length reference model.
module tb_io_switch_debounce;
  localparam int DB = 4;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        raw_sw0 = 1'b0;
  logic        raw_sw1 = 1'b0;
  logic        raw_pb0 = 1'b0;
  logic        clear_press = 1'b0;
  logic        io_sw0, io_sw1, io_pb0, pb0_press, pb0_latched;
  logic [15:0] io_rdata;
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  m_s1, m_s2, m_lvl;
  int          m_run [3];
  logic        m_press, m_latched;
  logic [2:0]  r;

  io_switch_debounce #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .raw_sw0(raw_sw0), .raw_sw1(raw_sw1),
    .raw_pb0(raw_pb0), .clear_press(clear_press), .io_sw0(io_sw0), .io_sw1(io_sw1),
    .io_pb0(io_pb0), .pb0_press(pb0_press), .pb0_latched(pb0_latched), .io_rdata(io_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0;
    m_press = 1'b0; m_latched = 1'b0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endtask

  // a level flips once the synchronized input has differed from it for DB consecutive edges
  task automatic model_edge(input logic [2:0] raw, input logic clr);
    logic rose;
    rose = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = m_s2[i];
          m_run[i] = 0;
          if (i == 0 && m_lvl[0]) rose = 1'b1;
        end
      end else m_run[i] = 0;
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_latched = m_press | (m_latched & ~clr);
    m_press = rose;
  endtask

  task automatic check_all();
    check("rdata", io_rdata, {13'd0, m_lvl});
    check("levels", {13'd0, io_sw1, io_sw0, io_pb0}, {13'd0, m_lvl});
    check("press", {15'd0, pb0_press}, {15'd0, m_press});
    check("latched", {15'd0, pb0_latched}, {15'd0, m_latched});
  endtask

  initial begin
    raw_sw0 = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("rst_rdata", io_rdata, 16'h0000);
    @(negedge clock) reset_n = 1'b1;
    for (int e = 1; e <= DB + 2; e++) begin
      @(posedge clock);
      #1;
      if (e < DB + 2) check("sw0_early", {15'd0, io_sw0}, 16'h0000);
      else begin
        check("sw0_rise", {15'd0, io_sw0}, 16'h0001);
        check("sw0_rdata", io_rdata, 16'h0002);
      end
    end
    @(negedge clock);
    reset_n = 1'b0; raw_sw0 = 1'b0;
    #1 check("async_rst", io_rdata, 16'h0000);
    model_reset();
    r = '0;
    @(negedge clock) reset_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      reset_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      clear_press = ($urandom_range(0, 5) == 0);
      raw_pb0 = r[0]; raw_sw0 = r[1]; raw_sw1 = r[2];
      if (!reset_n) begin
        model_reset();
        #1 check_all();
      end
      @(posedge clock);
      if (reset_n) model_edge(r, clear_press);
      else model_reset();
      #1 check_all();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_switch_debounce.md
IO_SWITCH_DEBOUNCE -- requirements
Module: io_switch_debounce

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 16'd50000, meaning the number of consecutive clock cycles a synchronized input must hold a new value before the debounced level changes; legal range 2..65535.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the debounce counter width; DB_CYCLES-1 SHALL fit in CNT_W bits.
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 raw_sw0  input  1  asynchronous sliding switch SW0 pin.
REQ-006 raw_sw1  input  1  asynchronous sliding switch SW1 pin.
REQ-007 raw_pb0  input  1  asynchronous pushbutton PB0 pin, 1 = pressed.
REQ-008 clear_press  input  1  synchronous strobe; clears pb0_latched.
REQ-009 io_sw0  output  1  debounced SW0 level, drives the switch input port bit 1.
REQ-010 io_sw1  output  1  debounced SW1 level, drives the switch input port bit 2.
REQ-011 io_pb0  output  1  debounced PB0 level, drives the switch input port bit 0.
REQ-012 pb0_press  output  1  one-cycle pulse on each debounced PB0 0->1 transition.
REQ-013 pb0_latched  output  1  sticky press flag, set by pb0_press, cleared by clear_press.
REQ-014 io_rdata  output  16  port word {13'd0, io_sw1, io_sw0, io_pb0}, the value returned for a read of address 16'hfff0.

Function
REQ-015 Each raw input SHALL pass through its own two-flop synchronizer (s1, s2) before any other logic.
REQ-016 Each of the three inputs SHALL have an independent debounce FSM with states STABLE and PENDING and its own CNT_W-bit counter cnt.
REQ-017 STABLE: if s2 == debounced level, cnt stays 0; else go to PENDING with cnt <= 1.
REQ-018 PENDING: if s2 == debounced level (glitch), go to STABLE with cnt <= 0 and the level unchanged.
REQ-019 PENDING: if s2 != level and cnt == DB_CYCLES-1, the level <= s2, cnt <= 0, and the FSM goes to STABLE; otherwise cnt <= cnt+1.
REQ-020 Latency: when a raw input settles at a new value sampled at rising edge E0, the debounced output SHALL change immediately after edge E0+DB_CYCLES+1, i.e. on the (DB_CYCLES+2)th sampling edge, and not earlier.
REQ-021 Any s2 return to the current level before that edge SHALL restart qualification from zero, with no output change.
REQ-022 Counter wrap-around SHALL be impossible; cnt never exceeds DB_CYCLES-1.
REQ-023 pb0_press SHALL be a registered pulse that is 1 for exactly the one cycle after io_pb0 goes 0->1, and 0 otherwise, including on a 1->0 transition.
REQ-024 pb0_latched SHALL be set by pb0_press and cleared by clear_press; if both occur in the same cycle, set wins and pb0_latched is 1.
REQ-025 io_rdata SHALL be purely combinational from the debounced registers, with bits [15:3] always 0.
REQ-026 The three channels SHALL be fully independent; simultaneous transitions on all inputs SHALL each resolve at their own latency.

Reset
REQ-027 While reset_n = 0, and immediately on its assertion, all of the following SHALL be 0: s1, s2, cnt, the debounced levels, pb0_press, pb0_latched and io_rdata; all FSMs SHALL be in STABLE.
REQ-028 Reset asserted while a channel is PENDING SHALL abort qualification; after release, a held raw value SHALL require the full DB_CYCLES+2 edges again.
REQ-029 Deassertion of reset_n SHALL produce no pb0_press pulse, even if raw_pb0 is 1.

Verification (DB_CYCLES=4)
REQ-030 Scenario 1: raw_sw0=1 held through reset, then reset_n released -> io_sw0=0 for 5 edges and 1 after the 6th edge; io_rdata=16'h0002.
REQ-031 Scenario 2: raw_sw1 pulses 1 for 3 cycles, then returns to 0 -> io_sw1 stays 0 throughout and io_rdata stays 16'h0000.
REQ-032 Scenario 3: raw_pb0 held 1 for 12 cycles, then 0 -> io_pb0 rises after the 6th edge; pb0_press is high exactly 1 cycle; pb0_latched stays 1 after release until a clear_press pulse, then 0; io_pb0 falls 6 edges after release with no pulse.
REQ-033 Scenario 4: clear_press asserted in the same cycle as pb0_press -> pb0_latched = 1.
REQ-034 Scenario 5: reset_n pulsed low with raw_sw1=1 while cnt=2 -> after release, io_sw1 rises only after 6 further edges.
REQ-035 Scenario 6: raw_sw1=1, raw_sw0=1 and raw_pb0=0 applied simultaneously -> both switches rise on the same cycle and io_rdata = 16'h0006.
